// File: rtl/tube_scan_driver_pkg.sv
// tube_pkg: shared definitions for the seven-segment scan driver.
//  - 5-bit character code constants
//  - 7-bit segment patterns, ordered {a,b,c,d,e,f,g} (bit 6 = a), active-high
//  - 32-entry code -> segment table (codes 24..31 decode as blank)
package tube_pkg;

  localparam int CODE_W     = 5;
  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 8;

  localparam logic [4:0] CH_DASH  = 5'd16;
  localparam logic [4:0] CH_BLANK = 5'd17;
  localparam logic [4:0] CH_P     = 5'd18;
  localparam logic [4:0] CH_L     = 5'd19;
  localparam logic [4:0] CH_H     = 5'd20;
  localparam logic [4:0] CH_U     = 5'd21;
  localparam logic [4:0] CH_R     = 5'd22;
  localparam logic [4:0] CH_N     = 5'd23;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_P     = 7'b1100111;
  localparam logic [6:0] SEG_L     = 7'b0001110;
  localparam logic [6:0] SEG_H     = 7'b0110111;
  localparam logic [6:0] SEG_U     = 7'b0111110;
  localparam logic [6:0] SEG_R     = 7'b0000101;
  localparam logic [6:0] SEG_N     = 7'b0010101;

  // Indexed directly by the 5-bit character code.
  localparam logic [6:0] SEG_TABLE [32] = '{
    SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F,
    SEG_DASH, SEG_BLANK, SEG_P, SEG_L, SEG_H, SEG_U, SEG_R, SEG_N,
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK
  };

endpackage

// File: rtl/tube_scan_driver_if.sv
// tube_scan_driver_if: bundle between the Main control logic and the scan driver.
//  enable, char_codes, dot_mask, blink_mask : Main -> driver
//  tube_character_left/right, tube_switch   : driver -> display
//  master modport = Main side, slave modport = scan driver.
interface tube_scan_driver_if;
  logic        enable;
  logic [39:0] char_codes;
  logic [7:0]  dot_mask;
  logic [7:0]  blink_mask;
  logic [7:0]  tube_character_left;
  logic [7:0]  tube_character_right;
  logic [7:0]  tube_switch;

  modport master (
    output enable, char_codes, dot_mask, blink_mask,
    input  tube_character_left, tube_character_right, tube_switch
  );

  modport slave (
    input  enable, char_codes, dot_mask, blink_mask,
    output tube_character_left, tube_character_right, tube_switch
  );
endinterface

// File: rtl/tube_scan_driver_seg_decode.sv
// tube_seg_decode: combinational 5-bit character code -> 7 segments {a..g}.
//  code_i : character code
//  seg_o  : segment pattern, active-high, no decimal point
module tube_seg_decode
  import tube_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/tube_scan_driver.sv
// tube_scan_driver: time-multiplexed driver for an 8-digit seven-segment display
// built from two 4-digit groups. Phase p lights digit p on the left bus and digit
// p+4 on the right bus. Input data is shadow-latched once per frame so the display
// never tears, and the first DEAD_CYC cycles of every phase keep tube_switch low.
//  clk   : system clock, rising edge
//  rst_n : asynchronous active-low reset
//  bus   : slave side of tube_scan_driver_if (codes/masks/enable in, segments/switch out)
module tube_scan_driver
  import tube_pkg::*;
#(
  parameter int SCAN_DIV     = 100_000,
  parameter int DEAD_CYC     = 1_000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                clk,
  input  logic                rst_n,
  tube_scan_driver_if.slave   bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEAD_LIM   = DIV_W'(DEAD_CYC);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [1:0]       PHASE_0    = 2'd0;
  localparam logic [1:0]       PHASE_1    = 2'd1;
  localparam logic [1:0]       PHASE_2    = 2'd2;
  localparam logic [1:0]       PHASE_LAST = 2'd3;

  logic [DIV_W-1:0] div_cnt_q,   div_cnt_d;
  logic [1:0]       phase_q,     phase_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             blink_off_q, blink_off_d;
  logic [39:0]      sh_codes_q,  sh_codes_d;
  logic [7:0]       sh_dot_q,    sh_dot_d;
  logic [7:0]       sh_blink_q,  sh_blink_d;
  logic [7:0]       left_q,      left_d;
  logic [7:0]       right_q,     right_d;
  logic [7:0]       switch_q,    switch_d;

  logic [4:0] left_code_s,  right_code_s;
  logic       left_dot_s,   right_dot_s;
  logic       left_blk_s,   right_blk_s;
  logic [6:0] left_seg_s,   right_seg_s;
  logic       load_s;

  // Scan divider, phase, frame counter and blink half-period toggle.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    phase_d     = phase_q;
    frame_cnt_d = frame_cnt_q;
    blink_off_d = blink_off_q;
    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      phase_d   = phase_q + 2'd1;
      if (phase_q == PHASE_LAST) begin
        if (frame_cnt_q == FRM_LAST) begin
          frame_cnt_d = '0;
          blink_off_d = ~blink_off_q;
        end else begin
          frame_cnt_d = frame_cnt_q + FRM_W'(1);
        end
      end else begin
        frame_cnt_d = frame_cnt_q;
      end
    end else begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end
  end

  // Shadow capture: only at the very first cycle of a frame, so a frame is
  // always drawn from one consistent snapshot.
  assign load_s = (div_cnt_q == '0) && (phase_q == PHASE_0);

  // Shadow register next-state.
  always_comb begin
    sh_codes_d = sh_codes_q;
    sh_dot_d   = sh_dot_q;
    sh_blink_d = sh_blink_q;
    if (load_s) begin
      sh_codes_d = bus.char_codes;
      sh_dot_d   = bus.dot_mask;
      sh_blink_d = bus.blink_mask;
    end else begin
      sh_codes_d = sh_codes_q;
    end
  end

  // Pick digit p for the left bus and digit p+4 for the right bus.
  always_comb begin
    left_code_s  = CH_BLANK;
    right_code_s = CH_BLANK;
    left_dot_s   = 1'b0;
    right_dot_s  = 1'b0;
    left_blk_s   = 1'b0;
    right_blk_s  = 1'b0;
    case (phase_q)
      PHASE_0: begin
        left_code_s  = sh_codes_q[39:35];
        right_code_s = sh_codes_q[19:15];
        left_dot_s   = sh_dot_q[7];
        right_dot_s  = sh_dot_q[3];
        left_blk_s   = sh_blink_q[7];
        right_blk_s  = sh_blink_q[3];
      end
      PHASE_1: begin
        left_code_s  = sh_codes_q[34:30];
        right_code_s = sh_codes_q[14:10];
        left_dot_s   = sh_dot_q[6];
        right_dot_s  = sh_dot_q[2];
        left_blk_s   = sh_blink_q[6];
        right_blk_s  = sh_blink_q[2];
      end
      PHASE_2: begin
        left_code_s  = sh_codes_q[29:25];
        right_code_s = sh_codes_q[9:5];
        left_dot_s   = sh_dot_q[5];
        right_dot_s  = sh_dot_q[1];
        left_blk_s   = sh_blink_q[5];
        right_blk_s  = sh_blink_q[1];
      end
      PHASE_LAST: begin
        left_code_s  = sh_codes_q[24:20];
        right_code_s = sh_codes_q[4:0];
        left_dot_s   = sh_dot_q[4];
        right_dot_s  = sh_dot_q[0];
        left_blk_s   = sh_blink_q[4];
        right_blk_s  = sh_blink_q[0];
      end
      default: begin
        left_code_s  = CH_BLANK;
        right_code_s = CH_BLANK;
      end
    endcase
  end

  tube_seg_decode u_dec_left (
    .code_i (left_code_s),
    .seg_o  (left_seg_s)
  );

  tube_seg_decode u_dec_right (
    .code_i (right_code_s),
    .seg_o  (right_seg_s)
  );

  // Output next-state: segments keep updating in dead time; only the digit
  // enables are gated. A blink-blanked digit keeps its enable for even duty.
  always_comb begin
    left_d   = {left_seg_s, left_dot_s};
    right_d  = {right_seg_s, right_dot_s};
    switch_d = 8'h00;
    if (left_blk_s && blink_off_q) begin
      left_d = 8'h00;
    end else begin
      left_d = {left_seg_s, left_dot_s};
    end
    if (right_blk_s && blink_off_q) begin
      right_d = 8'h00;
    end else begin
      right_d = {right_seg_s, right_dot_s};
    end
    if (!bus.enable || (div_cnt_q < DEAD_LIM)) begin
      switch_d = 8'h00;
    end else begin
      switch_d = (8'h80 >> phase_q) | (8'h08 >> phase_q);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q   <= '0;
      phase_q     <= PHASE_0;
      frame_cnt_q <= '0;
      blink_off_q <= 1'b0;
      sh_codes_q  <= {8{CH_BLANK}};
      sh_dot_q    <= 8'h00;
      sh_blink_q  <= 8'h00;
      left_q      <= 8'h00;
      right_q     <= 8'h00;
      switch_q    <= 8'h00;
    end else begin
      div_cnt_q   <= div_cnt_d;
      phase_q     <= phase_d;
      frame_cnt_q <= frame_cnt_d;
      blink_off_q <= blink_off_d;
      sh_codes_q  <= sh_codes_d;
      sh_dot_q    <= sh_dot_d;
      sh_blink_q  <= sh_blink_d;
      left_q      <= left_d;
      right_q     <= right_d;
      switch_q    <= switch_d;
    end
  end

  assign bus.tube_character_left  = left_q;
  assign bus.tube_character_right = right_q;
  assign bus.tube_switch          = switch_q;

endmodule
